// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with an IF/ID pipeline register. It keeps a single
// request outstanding to instruction memory, holds a returned word while
// decode is stalled, and throws away the response to a fetch that a branch
// redirect made obsolete.
//
// Ports
//   clk              in   sole clock, rising edge
//   rst              in   asynchronous, active-low reset
//   pcWrite          in   0 = freeze PC (hazard unit)
//   if_idWrite       in   0 = hold IF/ID register (hazard unit)
//   branchTaken      in   single-cycle redirect pulse from a later stage
//   branchTarget     in   redirect address, bits [1:0] ignored
//   imemReq          out  instruction memory request valid
//   imemAddr         out  word-aligned fetch address
//   imemReady        in   imemData valid this cycle (only while imemReq=1)
//   imemData         in   fetched instruction word
//   instruction_IFID out  IF/ID instruction
//   pcPlus4_IFID     out  IF/ID fetch address + 4
//   valid_IFID       out  IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pcWrite,
   input  logic        if_idWrite,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemReady,
   input  logic [31:0] imemData,
   output logic [31:0] instruction_IFID,
   output logic [31:0] pcPlus4_IFID,
   output logic        valid_IFID
);

   // S_REQ : request outstanding (or about to issue right after reset)
   // S_HOLD: returned word parked in hold_buf, waiting for the stall to clear
   // S_DROP: the outstanding response belongs to a redirected-away path
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_HOLD = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;          // current fetch address, drives imemAddr
   logic        req_q, req_d;
   logic [31:0] hold_buf_q, hold_buf_d;
   logic [31:0] tgt_q, tgt_d;        // stored redirect target while in S_DROP
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic        resp;
   logic        stall;
   logic        load_word;
   logic [31:0] load_data;
   logic [31:0] br_tgt;
   logic [31:0] pc_plus4;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      hold_buf_d = hold_buf_q;
      tgt_d      = tgt_q;
      instr_d    = instr_q;
      pc4_d      = pc4_q;
      valid_d    = valid_q;
      load_word  = 1'b0;
      load_data  = 32'h0;

      // A response only counts while our request is actually on the bus;
      // right after reset the request has not been raised yet.
      resp     = req_q & imemReady;
      stall    = ~pcWrite | ~if_idWrite;
      br_tgt   = branchTarget & ~32'h3;
      pc_plus4 = pc_q + 32'd4;

      unique case (state_q)
         S_REQ: begin
            if (branchTaken) begin
               if (resp || !req_q) begin
                  pc_d = br_tgt;
               end else begin
                  // Cannot cancel a pending request: wait for its response
                  // and discard it, keeping imemAddr stable meanwhile.
                  state_d = S_DROP;
                  tgt_d   = br_tgt;
               end
            end else if (resp) begin
               if (stall) begin
                  hold_buf_d = imemData;
                  state_d    = S_HOLD;
               end else begin
                  load_word = 1'b1;
                  load_data = imemData;
                  pc_d      = pc_plus4;
               end
            end
         end

         S_HOLD: begin
            if (branchTaken) begin
               pc_d    = br_tgt;
               state_d = S_REQ;
            end else if (!stall) begin
               load_word = 1'b1;
               load_data = hold_buf_q;
               pc_d      = pc_plus4;
               state_d   = S_REQ;
            end
         end

         S_DROP: begin
            if (branchTaken) begin
               tgt_d = br_tgt;                 // latest redirect wins
            end
            if (imemReady) begin
               pc_d    = branchTaken ? br_tgt : tgt_q;
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase

      // IF/ID update: flush beats everything, then a delivered word, then
      // a bubble when decode is accepting but nothing arrived.
      if (branchTaken) begin
         valid_d = 1'b0;
         instr_d = 32'h0;
      end else if (load_word) begin
         valid_d = 1'b1;
         instr_d = load_data;
         pc4_d   = pc_plus4;
      end else if (if_idWrite) begin
         valid_d = 1'b0;
         instr_d = 32'h0;
      end

      // Request is registered so it is low during reset and rises on the
      // first edge after release.
      req_d = (state_d != S_HOLD);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         hold_buf_q <= 32'h0;
         tgt_q      <= 32'h0;
         instr_q    <= 32'h0;
         pc4_q      <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         hold_buf_q <= hold_buf_d;
         tgt_q      <= tgt_d;
         instr_q    <= instr_d;
         pc4_q      <= pc4_d;
         valid_q    <= valid_d;
      end
   end

   assign imemReq          = req_q;
   assign imemAddr         = pc_q;
   assign instruction_IFID = instr_q;
   assign pcPlus4_IFID     = pc4_q;
   assign valid_IFID       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Every word the memory model hands over that
// must reach decode is pushed to a scoreboard queue when the stimulus is
// driven; a negedge monitor pops and compares each real IF/ID load, checks
// flushes, and checks that a pending request stays stable.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcWrite;
   logic        if_idWrite;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemReady;
   logic [31:0] imemData;
   logic [31:0] instruction_IFID;
   logic [31:0] pcPlus4_IFID;
   logic        valid_IFID;
   logic        bad_data;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .pcWrite          (pcWrite),
      .if_idWrite       (if_idWrite),
      .branchTaken      (branchTaken),
      .branchTarget     (branchTarget),
      .imemReq          (imemReq),
      .imemAddr         (imemAddr),
      .imemReady        (imemReady),
      .imemData         (imemData),
      .instruction_IFID (instruction_IFID),
      .pcPlus4_IFID     (pcPlus4_IFID),
      .valid_IFID       (valid_IFID)
   );

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Memory model: the word is a fixed function of the requested address,
   // except when a poisoned response is being injected.
   assign imemData = bad_data ? 32'hDEAD_BEEF : word_at(imemAddr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   task automatic push_exp(input logic [31:0] a);
      exp_t e;
      e.instr = word_at(a);
      e.pc4   = a + 32'd4;
      sb_q.push_back(e);
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor
   initial begin
      logic        load_flag;
      logic        flush_flag;
      logic        pend_flag;
      logic [31:0] pend_addr;
      exp_t        e;
      load_flag  = 1'b0;
      flush_flag = 1'b0;
      pend_flag  = 1'b0;
      pend_addr  = 32'h0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            if (flush_flag) begin
               check("flush_valid", {31'h0, valid_IFID}, 32'h0);
               check("flush_instr", instruction_IFID, 32'h0);
            end else if (load_flag && valid_IFID) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_load", instruction_IFID, 32'h0);
               end else begin
                  e = sb_q.pop_front();
                  check("ifid_instr", instruction_IFID, e.instr);
                  check("ifid_pc4", pcPlus4_IFID, e.pc4);
                  $display("load instr=%08h pc4=%08h", instruction_IFID, pcPlus4_IFID);
               end
            end
            if (pend_flag) begin
               check("stable_req", {31'h0, imemReq}, 32'h1);
               check("stable_addr", imemAddr, pend_addr);
            end
         end
         load_flag  = rst && if_idWrite && !branchTaken;
         flush_flag = rst && branchTaken;
         pend_flag  = rst && imemReq && !imemReady;
         pend_addr  = imemAddr;
      end
   end

   // Watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; pcWrite = 1'b0; if_idWrite = 1'b0; branchTaken = 1'b0;
      branchTarget = 32'h0; imemReady = 1'b0; bad_data = 1'b0;
      #3;
      check("rst_req", {31'h0, imemReq}, 32'h0);
      check("rst_valid", {31'h0, valid_IFID}, 32'h0);
      check("rst_instr", instruction_IFID, 32'h0);
      check("rst_pc4", pcPlus4_IFID, 32'h0);
      step(); step();
      check("rst_req_clk", {31'h0, imemReq}, 32'h0);
      rst = 1'b1;
      step();
      check("first_req", {31'h0, imemReq}, 32'h1);
      check("first_addr", imemAddr, 32'h0);

      // Streaming, one instruction per cycle
      pcWrite = 1'b1; if_idWrite = 1'b1; imemReady = 1'b1;
      for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
      repeat (4) step();
      imemReady = 1'b0;
      check("stream_addr", imemAddr, 32'h10);

      // Stall for 3 cycles with a word returned: HOLD
      pcWrite = 1'b0; if_idWrite = 1'b0; imemReady = 1'b1;
      push_exp(32'h10);
      repeat (3) step();
      check("hold_req", {31'h0, imemReq}, 32'h0);
      check("hold_valid", {31'h0, valid_IFID}, 32'h1);
      check("hold_instr", instruction_IFID, word_at(32'hC));
      check("hold_pc4", pcPlus4_IFID, 32'h10);
      pcWrite = 1'b1; if_idWrite = 1'b1; imemReady = 1'b0;
      step();
      check("release_req", {31'h0, imemReq}, 32'h1);
      check("release_addr", imemAddr, 32'h14);
      imemReady = 1'b1; push_exp(32'h14);
      step();
      imemReady = 1'b0;

      // Branch with response this cycle, while stalled (priority over pcWrite=0)
      pcWrite = 1'b0; if_idWrite = 1'b0;
      branchTaken = 1'b1; branchTarget = 32'h0000_0103; imemReady = 1'b1;
      step();
      branchTaken = 1'b0; imemReady = 1'b0; pcWrite = 1'b1; if_idWrite = 1'b1;
      check("br_addr", imemAddr, 32'h100);
      check("br_req", {31'h0, imemReq}, 32'h1);

      // DROP: branch while response pending, poisoned response later
      imemReady = 1'b1; push_exp(32'h100);
      step();
      imemReady = 1'b0; branchTaken = 1'b1; branchTarget = 32'h200;
      step();
      branchTaken = 1'b0;
      step();
      check("drop_addr_stable", imemAddr, 32'h104);
      bad_data = 1'b1; imemReady = 1'b1;
      step();
      bad_data = 1'b0; imemReady = 1'b0;
      check("drop_target", imemAddr, 32'h200);
      imemReady = 1'b1; push_exp(32'h200);
      step();
      imemReady = 1'b0;

      // Two redirects while in DROP: latest wins
      branchTaken = 1'b1; branchTarget = 32'h40;
      step();
      branchTarget = 32'h80;
      step();
      branchTaken = 1'b0;
      step();
      imemReady = 1'b1;
      step();
      imemReady = 1'b0;
      check("drop2_target", imemAddr, 32'h80);
      imemReady = 1'b1; push_exp(32'h80);
      step();

      // Address wrap at the top of memory
      branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFF;
      step();
      branchTaken = 1'b0; imemReady = 1'b0;
      check("top_addr", imemAddr, 32'hFFFF_FFFC);
      imemReady = 1'b1; push_exp(32'hFFFF_FFFC);
      step();
      imemReady = 1'b0;
      check("wrap_addr", imemAddr, 32'h0);
      imemReady = 1'b1; push_exp(32'h0);
      step();
      imemReady = 1'b0;

      // Asynchronous reset in the middle of HOLD
      pcWrite = 1'b0; if_idWrite = 1'b0; imemReady = 1'b1;
      step();
      imemReady = 1'b0;
      check("hold2_req", {31'h0, imemReq}, 32'h0);
      #2 rst = 1'b0;
      #1;
      check("async_req", {31'h0, imemReq}, 32'h0);
      check("async_valid", {31'h0, valid_IFID}, 32'h0);
      check("async_instr", instruction_IFID, 32'h0);
      check("async_pc4", pcPlus4_IFID, 32'h0);
      step();
      rst = 1'b1;
      check("rel_req_low", {31'h0, imemReq}, 32'h0);
      step();
      check("rel_req", {31'h0, imemReq}, 32'h1);
      check("rel_addr", imemAddr, 32'h0);
      pcWrite = 1'b1; if_idWrite = 1'b1; imemReady = 1'b1; push_exp(32'h0);
      step();
      imemReady = 1'b0;
      step(); step();
      check("sb_empty", 32'(sb_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
